sum_axil_slave: RTL

SUM_AXIL_SLAVE -- requirements
Module: sum_axil_slave

---
 rtl/sum_axil_pkg.sv | 32 +++
 rtl/sum_axil_core.sv | 76 +++++++
 rtl/sum_axil_slave.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sum_axil_pkg.sv
// Shared constants and types for the AXI4-Lite adder peripheral.
package sum_axil_pkg;

  localparam logic [1:0] REG_OP_A   = 2'd0;
  localparam logic [1:0] REG_OP_B   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_DONE_BIT  = 1;
  localparam int CTRL_OVF_BIT   = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/sum_axil_core.sv
// Compute engine: captures two operands on start, produces a 33-bit sum.
//   state   | meaning
//   IDLE    | waiting for start; start is accepted only here
//   CALC    | operands latched, sum registered on exit
//   DONE_ST | result valid, irq high for this one cycle
module sum_axil_core
  import sum_axil_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result,
  output logic        ovf,
  output logic        done,
  output logic        busy,
  output logic        irq
);

  state_e      state_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [31:0] result_q;
  logic        ovf_q;
  logic        done_q;
  logic        busy_q;
  logic        irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opa_q   <= op_a;
            opb_q   <= op_b;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          {ovf_q, result_q} <= {1'b0, opa_q} + {1'b0, opb_q};
          done_q  <= 1'b1;
          irq_q   <= 1'b1;
          state_q <= DONE_ST;
        end
        DONE_ST: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign irq    = irq_q;

endmodule

// File: rtl/sum_axil_slave.sv
// AXI4-Lite slave with operand/control/result registers around sum_axil_core.
// Optional SUM_AXIL_AUTO_START_EN: any accepted OP_B write also starts a sum.
module sum_axil_slave
  import sum_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            busy,
  output logic                            irq
);

  logic        aw_ready_q, aw_ready_d;
  logic        bvalid_q, bvalid_d;
  logic        ar_ready_q, ar_ready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;

  logic        wr_hs, rd_hs, start;
  logic [1:0]  wr_idx, rd_idx;
  logic [31:0] rd_mux, ctrl_rd;
  logic [31:0] result;
  logic        ovf, done;

  logic unused_in;
  assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx = S_AXI_AWADDR[3:2];
  assign rd_idx = S_AXI_ARADDR[3:2];
  assign wr_hs  = aw_ready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_hs  = ar_ready_q && S_AXI_ARVALID;

  // Ready may be raised while the previous response is being consumed,
  // so it is only ever high in a cycle where BVALID is low.
  always_comb begin
    aw_ready_d = S_AXI_AWVALID && S_AXI_WVALID && !aw_ready_q &&
                 (!bvalid_q || S_AXI_BREADY);
    bvalid_d   = wr_hs ? 1'b1 : (bvalid_q && !S_AXI_BREADY);
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    start      = 1'b0;
    if (wr_hs) begin
      if (wr_idx == REG_OP_A) op_a_d = apply_wstrb(op_a_q, S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_idx == REG_OP_B) op_b_d = apply_wstrb(op_b_q, S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_idx == REG_CTRL && S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_START_BIT]) start = 1'b1;
`ifdef SUM_AXIL_AUTO_START_EN
      if (wr_idx == REG_OP_B) start = 1'b1;
`endif
    end
  end

  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[CTRL_DONE_BIT] = done;
    ctrl_rd[CTRL_OVF_BIT]  = ovf;
    case (rd_idx)
      REG_OP_A:   rd_mux = op_a_q;
      REG_OP_B:   rd_mux = op_b_q;
      REG_CTRL:   rd_mux = ctrl_rd;
      REG_RESULT: rd_mux = result;
      default:    rd_mux = '0;
    endcase
    ar_ready_d = S_AXI_ARVALID && !rvalid_q && !ar_ready_q;
    rvalid_d   = rd_hs ? 1'b1 : (rvalid_q && !S_AXI_RREADY);
    rdata_d    = rd_hs ? rd_mux : rdata_q;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_ready_q <= 1'b0;
      bvalid_q   <= 1'b0;
      ar_ready_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
    end else begin
      aw_ready_q <= aw_ready_d;
      bvalid_q   <= bvalid_d;
      ar_ready_q <= ar_ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
    end
  end

  // Next-state operand values let an auto-start see the OP_B being written.
  sum_axil_core u_core (
    .clk    (S_AXI_ACLK),
    .rst    (S_AXI_ARESET),
    .start  (start),
    .op_a   (op_a_d),
    .op_b   (op_b_d),
    .result (result),
    .ovf    (ovf),
    .done   (done),
    .busy   (busy),
    .irq    (irq)
  );

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule
